// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_arbiter
// Purpose  : Round-robin sharing of the fret-sprite BRAM read port among the
//            string renderers, with index-tagged read return.
// Options  : SPRITE_ARB_STATS_EN enables the contention counter on o_stall_count.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch_arbiter #(
    parameter int NUM_REQ     = 6,
    parameter int NUM_SPRITES = 18,
    parameter int ROM_LAT     = 1
) (
    input  logic                   i_clk65,
    input  logic                   i_reset,
    input  logic                   i_hold,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [10*NUM_REQ-1:0]  i_req_addr,
    input  logic [5*NUM_REQ-1:0]   i_req_sel,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_rom_en,
    output logic [9:0]             o_rom_addr,
    output logic [4:0]             o_rom_sel,
    input  logic [12:0]            i_rom_data,
    output logic [12:0]            o_rd_data,
    output logic [NUM_REQ-1:0]     o_rd_valid,
    output logic [15:0]            o_stall_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] r_grant;
    logic               r_rom_en;
    logic [9:0]         r_rom_addr;
    logic [4:0]         r_rom_sel;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_tag [ROM_LAT];
    logic [ROM_LAT-1:0] r_bad;
    logic [12:0]        r_rd_data;
    logic [NUM_REQ-1:0] r_rd_valid;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_found;
    logic               w_issue;
    int                 w_hi;
    int                 w_lo;
    logic               w_hi_found;
    int                 w_win;
    logic [9:0]         w_addr;
    logic [4:0]         w_sel;
    logic [PW-1:0]      w_ptr_next;
    logic               w_cur_bad;

    // The requester currently holding grant is masked to prevent a double grant.
    always_comb begin
        w_elig     = i_req & ~r_grant;
        w_hi       = 0;
        w_lo       = 0;
        w_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = i;
                end else begin
                    w_lo = i;
                end
            end
        end
        w_win   = w_hi_found ? w_hi : w_lo;
        w_found = |w_elig;
        w_issue = w_found & ~i_hold;
    end

    always_comb begin
        w_onehot = '0;
        w_addr   = '0;
        w_sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_issue && (w_win == i)) begin
                w_onehot[i] = 1'b1;
                w_addr      = i_req_addr[i*10 +: 10];
                w_sel       = i_req_sel[i*5 +: 5];
            end
        end
        w_ptr_next = (w_win + 1 >= NUM_REQ) ? '0 : PW'(w_win + 1);
        w_cur_bad  = int'(r_rom_sel) >= NUM_SPRITES;
    end

    always_ff @(posedge i_clk65) begin
        if (!i_reset) begin
            r_grant    <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_rom_sel  <= '0;
            r_ptr      <= '0;
        end else begin
            r_grant  <= w_onehot;
            r_rom_en <= w_issue;
            if (w_issue) begin
                r_rom_addr <= w_addr;
                r_rom_sel  <= w_sel;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    // Tag stage 0 is loaded one cycle after the grant so the last stage lines
    // up with the cycle in which rom_data is valid.
    always_ff @(posedge i_clk65) begin
        if (!i_reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= '0;
            end
            r_bad      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_tag[0] <= r_grant;
            r_bad[0] <= w_cur_bad;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
                r_bad[i] <= r_bad[i-1];
            end
            r_rd_valid <= r_tag[ROM_LAT-1];
            if (|r_tag[ROM_LAT-1]) begin
                r_rd_data <= r_bad[ROM_LAT-1] ? 13'h0000 : i_rom_data;
            end
        end
    end

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] r_stall;
    int          w_cnt;
    logic [16:0] w_stall_sum;

    // A hold-stall with several eligible requesters counts under both rules.
    always_comb begin
        w_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cnt = w_cnt + int'(w_elig[i]);
        end
        w_stall_sum = {1'b0, r_stall}
                    + {16'h0000, (w_found & ~w_issue)}
                    + {16'h0000, (w_cnt > 1)};
    end

    always_ff @(posedge i_clk65) begin
        if (!i_reset) begin
            r_stall <= '0;
        end else begin
            r_stall <= w_stall_sum[16] ? 16'hFFFF : w_stall_sum[15:0];
        end
    end

    assign o_stall_count = r_stall;
`else
    assign o_stall_count = 16'h0000;
`endif

    assign o_grant    = r_grant;
    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_rom_sel  = r_rom_sel;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch_arbiter
// Purpose  : Randomised and directed bench for sprite_fetch_arbiter against a
//            cycle-level reference model of the arbitration and return rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_arbiter;

    localparam int N   = 6;
    localparam int NS  = 18;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    req;
    logic [10*N-1:0] req_addr;
    logic [5*N-1:0]  req_sel;
    logic [N-1:0]    grant;
    logic            rom_en;
    logic [9:0]      rom_addr;
    logic [4:0]      rom_sel;
    logic [12:0]     rom_data;
    logic [12:0]     rd_data;
    logic [N-1:0]    rd_valid;
    logic [15:0]     stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_fetch_arbiter #(.NUM_REQ(N), .NUM_SPRITES(NS), .ROM_LAT(LAT)) dut (
        .i_clk65      (clk),
        .i_reset      (rst_n),
        .i_hold       (hold),
        .i_req        (req),
        .i_req_addr   (req_addr),
        .i_req_sel    (req_sel),
        .o_grant      (grant),
        .o_rom_en     (rom_en),
        .o_rom_addr   (rom_addr),
        .o_rom_sel    (rom_sel),
        .i_rom_data   (rom_data),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_stall_count(stall_count)
    );

    function automatic logic [12:0] rom_word(input logic [4:0] s, input logic [9:0] a);
        return {s, 8'h00} ^ {3'b000, a} ^ 13'h00A5;
    endfunction

    // Behavioural BRAM: word appears LAT cycles after the enable cycle.
    logic [12:0] rom_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
        rom_pipe[0] <= rom_en ? rom_word(rom_sel, rom_addr) : 13'h1ABC;
    end
    assign rom_data = rom_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        int          idx;
        logic [12:0] data;
    } ret_t;
    ret_t        m_q[$];
    int          m_ptr, m_g, cyc;
    logic [9:0]  m_addr;
    logic [4:0]  m_sel;
    int          m_stall;
    logic        e_en;
    logic [N-1:0] e_grant, e_valid;
    logic [12:0] e_data;

    task automatic step();
        logic [N-1:0] gm, el;
        int w, idx, inc;
        ret_t r;
        gm = '0;
        if (m_g >= 0) gm[m_g] = 1'b1;
        el = req & ~gm;
        w  = -1;
        if (!rst_n) begin
            m_ptr = 0; m_g = -1; m_addr = '0; m_sel = '0; m_stall = 0;
            m_q.delete(); e_data = '0;
        end else begin
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && el[idx]) w = idx;
                end
            end
`ifdef SPRITE_ARB_STATS_EN
            inc = ((el != 0 && w < 0) ? 1 : 0) + (($countones(el) > 1) ? 1 : 0);
            m_stall = m_stall + inc;
            if (m_stall > 65535) m_stall = 65535;
`else
            inc = 0;
`endif
            if (w >= 0) begin
                m_ptr  = (w + 1) % N;
                m_addr = req_addr[w*10 +: 10];
                m_sel  = req_sel[w*5 +: 5];
                r.due  = cyc + LAT + 2;
                r.idx  = w;
                r.data = (m_sel >= NS) ? 13'h0000 : rom_word(m_sel, m_addr);
                m_q.push_back(r);
            end
            m_g = w;
        end
        e_en    = (w >= 0);
        e_grant = '0;
        if (w >= 0) e_grant[w] = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        e_valid = '0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            r = m_q.pop_front();
            e_valid[r.idx] = 1'b1;
            e_data = r.data;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; hold = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; req = '1;
        req_addr = '1; req_sel = '1;
        step(); step();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
        checks++; if (rom_addr !== 10'd0 || rom_sel !== 5'd0) begin errors++; $display("FAIL reset_rom_addr_sel got=%0d/%0d exp=0/0", rom_addr, rom_sel); end
        checks++; if (rd_valid !== '0 || rd_data !== 13'd0) begin errors++; $display("FAIL reset_rd got=%b/%h exp=0/0", rd_valid, rd_data); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
        req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 6'b000001; req_addr[9:0] = 10'd37; req_sel[4:0] = 5'd3;
        step();
        checks++; if (grant !== 6'b000001) begin errors++; $display("FAIL single_grant got=%b exp=000001", grant); end
        checks++; if (rom_en !== 1'b1 || rom_addr !== 10'd37 || rom_sel !== 5'd3) begin errors++; $display("FAIL single_rom got=%b/%0d/%0d exp=1/37/3", rom_en, rom_addr, rom_sel); end
        req = '0;
        for (int i = 0; i < LAT; i++) step();
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", rd_valid); end
        step();
        checks++; if (rd_valid !== 6'b000001 || rd_data !== rom_word(5'd3, 10'd37)) begin errors++; $display("FAIL single_return got=%b/%h exp=000001/%h", rd_valid, rd_data, rom_word(5'd3, 10'd37)); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] hist[$];
        logic [N-1:0] exp1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*10 +: 10] = 10'(i * 50 + 1);
            req_sel[i*5 +: 5]    = 5'(i + 1);
        end
        req = '1;
        for (int c = 0; c < 14; c++) begin
            step();
            exp1 = '0; exp1[c % N] = 1'b1;
            checks++; if (grant !== exp1 || grant !== e_grant) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp1); end
            hist.push_back(grant);
            if (c >= LAT + 1) begin
                checks++; if (rd_valid !== hist[c-LAT-1] || rd_data !== e_data) begin errors++; $display("FAIL rr_return c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, hist[c-LAT-1], e_data); end
            end
        end
        req = '0;
        for (int i = 0; i < LAT + 2; i++) step();
    endtask

    task automatic test_bad_sel();
        do_reset();
        req = 6'b000001; req_addr[9:0] = 10'd100; req_sel[4:0] = 5'd20;
        step();
        checks++; if (grant !== 6'b000001 || rom_en !== 1'b1 || rom_sel !== 5'd20) begin errors++; $display("FAIL bad_issue got=%b/%b/%0d exp=000001/1/20", grant, rom_en, rom_sel); end
        req = '0;
        for (int i = 0; i < LAT + 1; i++) step();
        checks++; if (rd_valid !== 6'b000001 || rd_data !== 13'h0000) begin errors++; $display("FAIL bad_return got=%b/%h exp=000001/0000", rd_valid, rd_data); end
    endtask

    task automatic test_hold();
        do_reset();
        hold = 1'b1; req = 6'b001100;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (grant !== '0 || rom_en !== 1'b0) begin errors++; $display("FAIL hold_nogrant c=%0d got=%b/%b exp=0/0", c, grant, rom_en); end
        end
        checks++; if (stall_count !== 16'(m_stall)) begin errors++; $display("FAIL hold_stall got=%0d exp=%0d", stall_count, m_stall); end
        hold = 1'b0;
        step();
        checks++; if (grant !== 6'b000100) begin errors++; $display("FAIL hold_first got=%b exp=000100", grant); end
        step();
        checks++; if (grant !== 6'b001000) begin errors++; $display("FAIL hold_second got=%b exp=001000", grant); end
        req = '0;
        for (int i = 0; i < LAT + 2; i++) step();
    endtask

    task automatic test_reset_midread();
        do_reset();
        req = 6'b000001; req_sel[4:0] = 5'd2;
        step();
        rst_n = 1'b0; req = '0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            checks++; if (rd_valid !== '0 || stall_count !== 16'd0) begin errors++; $display("FAIL midreset_flush c=%0d got=%b/%0d exp=0/0", c, rd_valid, stall_count); end
            step();
        end
        req = 6'b100001;
        step();
        checks++; if (grant !== 6'b000001) begin errors++; $display("FAIL midreset_ptr got=%b exp=000001", grant); end
        req = '0;
        for (int i = 0; i < LAT + 2; i++) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            hold     = ($urandom_range(0, 4) == 0);
            req      = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*10 +: 10] = 10'($urandom);
                req_sel[i*5 +: 5]    = 5'($urandom_range(0, 23));
            end
            step();
            checks++; if (grant !== e_grant || rom_en !== e_en) begin errors++; $display("FAIL rand_grant c=%0d got=%b/%b exp=%b/%b", c, grant, rom_en, e_grant, e_en); end
            checks++; if (rom_addr !== m_addr || rom_sel !== m_sel) begin errors++; $display("FAIL rand_rom c=%0d got=%0d/%0d exp=%0d/%0d", c, rom_addr, rom_sel, m_addr, m_sel); end
            checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rd_valid, e_valid); end
            if (e_valid != '0) begin
                checks++; if (rd_data !== e_data) begin errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rd_data, e_data); end
            end
            checks++; if (stall_count !== 16'(m_stall)) begin errors++; $display("FAIL rand_stall c=%0d got=%0d exp=%0d", c, stall_count, m_stall); end
        end
        rst_n = 1'b1; hold = 1'b0; req = '0;
    endtask

    task automatic test_stats();
        int expv;
        do_reset();
        req = 6'b000011;
        for (int c = 0; c < 10; c++) step();
        req = '0;
`ifdef SPRITE_ARB_STATS_EN
        expv = 1;
`else
        expv = 0;
`endif
        checks++; if (stall_count !== 16'(m_stall) || stall_count !== 16'(expv)) begin errors++; $display("FAIL stats_count got=%0d exp=%0d", stall_count, expv); end
    endtask

    initial begin
        cyc = 0; m_ptr = 0; m_g = -1; m_addr = '0; m_sel = '0; m_stall = 0;
        e_en = 1'b0; e_grant = '0; e_valid = '0; e_data = '0;
        rst_n = 1'b0; hold = 1'b0; req = '0; req_addr = '0; req_sel = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_bad_sel();
        test_hold();
        test_reset_midread();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
